// File: rtl/serial_link_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : serial_link_pkg
// Purpose  : Shared frame geometry and TX state encoding for the serial link.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
package serial_link_pkg;

  localparam int OPC_W      = 5;
  localparam int DATA_W     = 32;
  localparam int FRAME_BITS = OPC_W + DATA_W;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_LOW  = 2'd1,
    TX_HIGH = 2'd2,
    TX_GAP  = 2'd3
  } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/serial_link_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : serial_link_if
// Purpose  : Host-side send/receive handshakes plus the four serial wires.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
interface serial_link_if;
  import serial_link_pkg::*;

  logic              send_valid;
  logic              send_ready;
  logic [OPC_W-1:0]  send_opcode;
  logic [DATA_W-1:0] send_data;
  logic              serial_data_out;
  logic              serial_clock_out;
  logic              serial_data_in;
  logic              serial_clock_in;
  logic              recv_valid;
  logic              recv_ready;
  logic [OPC_W-1:0]  recv_opcode;
  logic [DATA_W-1:0] recv_data;
  logic              rx_error;
  logic              err_clear;

  // Host logic and far-end wires
  modport master (
    output send_valid, send_opcode, send_data, recv_ready, err_clear,
    output serial_data_in, serial_clock_in,
    input  send_ready, recv_valid, recv_opcode, recv_data, rx_error,
    input  serial_data_out, serial_clock_out
  );

  // Link endpoint
  modport slave (
    input  send_valid, send_opcode, send_data, recv_ready, err_clear,
    input  serial_data_in, serial_clock_in,
    output send_ready, recv_valid, recv_opcode, recv_data, rx_error,
    output serial_data_out, serial_clock_out
  );

endinterface
`default_nettype wire

// File: rtl/serial_sync_edge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : serial_sync_edge
// Purpose  : Two-flop synchronizer with a one-cycle rising-edge pulse.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module serial_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/serial_link_host.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : serial_link_host
// Purpose  : Serial link endpoint: frame serializer (TX) and deserializer (RX).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module serial_link_host
  import serial_link_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int RX_TIMEOUT = 256
) (
  input  logic         clock,
  input  logic         reset,
  serial_link_if.slave bus
);

  localparam int c_DIV_W = $clog2(CLK_DIV);
  localparam int c_TO_W  = $clog2(RX_TIMEOUT + 1);

  // ---------------- TX ----------------
  tx_state_e             r_tx_state;
  tx_state_e             w_tx_state_nxt;
  logic [c_DIV_W-1:0]    r_div_cnt;
  logic [CNT_W-1:0]      r_tx_bits;
  logic [FRAME_BITS-1:0] r_tx_shift;
  logic                  w_div_done;
  logic                  w_last_bit;

  assign w_div_done = (r_div_cnt == c_DIV_W'(CLK_DIV - 1));
  assign w_last_bit = (r_tx_bits == CNT_W'(FRAME_BITS - 1));

  always_comb begin
    w_tx_state_nxt       = r_tx_state;
    bus.send_ready       = 1'b0;
    bus.serial_clock_out = 1'b0;
    bus.serial_data_out  = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        bus.send_ready = 1'b1;
        if (bus.send_valid) w_tx_state_nxt = TX_LOW;
      end
      TX_LOW: begin
        bus.serial_data_out = r_tx_shift[FRAME_BITS-1];
        if (w_div_done) w_tx_state_nxt = TX_HIGH;
      end
      TX_HIGH: begin
        bus.serial_clock_out = 1'b1;
        bus.serial_data_out  = r_tx_shift[FRAME_BITS-1];
        if (w_div_done) w_tx_state_nxt = w_last_bit ? TX_GAP : TX_LOW;
      end
      TX_GAP: begin
        if (w_div_done) w_tx_state_nxt = TX_IDLE;
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tx_state <= TX_IDLE;
      r_div_cnt  <= '0;
      r_tx_bits  <= '0;
      r_tx_shift <= '0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      if (r_tx_state == TX_IDLE || w_div_done) r_div_cnt <= '0;
      else                                     r_div_cnt <= r_div_cnt + 1'b1;
      if (r_tx_state == TX_IDLE && bus.send_valid) begin
        r_tx_shift <= {bus.send_opcode, bus.send_data};
        r_tx_bits  <= '0;
      end else if (r_tx_state == TX_HIGH && w_div_done && !w_last_bit) begin
        // Shift at the end of HIGH so the next bit settles while the clock is low
        r_tx_shift <= {r_tx_shift[FRAME_BITS-2:0], 1'b0};
        r_tx_bits  <= r_tx_bits + 1'b1;
      end
    end
  end

  // ---------------- RX ----------------
  logic                  w_rx_rise;
  logic                  r_din_meta;
  logic                  r_din_sync;
  logic [FRAME_BITS-1:0] r_rx_shift;
  logic [CNT_W-1:0]      r_rx_cnt;
  logic [c_TO_W-1:0]     r_idle_cnt;
  logic                  r_recv_valid;
  logic [OPC_W-1:0]      r_recv_opcode;
  logic [DATA_W-1:0]     r_recv_data;
  logic                  r_rx_error;
  logic                  w_rx_done;
  logic                  w_rx_timeout;
  logic                  w_overrun;

  serial_sync_edge u_clk_sync (
    .clk     (clock),
    .rst     (reset),
    .i_async (bus.serial_clock_in),
    .o_rise  (w_rx_rise)
  );

  // Data sync has the same two-flop latency as the clock path, keeping them aligned
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_din_meta <= 1'b0;
      r_din_sync <= 1'b0;
    end else begin
      r_din_meta <= bus.serial_data_in;
      r_din_sync <= r_din_meta;
    end
  end

  assign w_rx_done    = (r_rx_cnt == CNT_W'(FRAME_BITS));
  assign w_rx_timeout = (r_rx_cnt != '0) && !w_rx_done && !w_rx_rise &&
                        (r_idle_cnt == c_TO_W'(RX_TIMEOUT - 1));
  assign w_overrun    = w_rx_done && r_recv_valid && !bus.recv_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rx_shift    <= '0;
      r_rx_cnt      <= '0;
      r_idle_cnt    <= '0;
      r_recv_valid  <= 1'b0;
      r_recv_opcode <= '0;
      r_recv_data   <= '0;
      r_rx_error    <= 1'b0;
    end else begin
      if (w_rx_done || w_rx_timeout) begin
        r_rx_cnt   <= '0;
        r_idle_cnt <= '0;
      end else if (w_rx_rise) begin
        r_rx_shift <= {r_rx_shift[FRAME_BITS-2:0], r_din_sync};
        r_rx_cnt   <= r_rx_cnt + 1'b1;
        r_idle_cnt <= '0;
      end else if (r_rx_cnt != '0) begin
        r_idle_cnt <= r_idle_cnt + 1'b1;
      end

      if (w_rx_done && (!r_recv_valid || bus.recv_ready)) begin
        r_recv_valid  <= 1'b1;
        r_recv_opcode <= r_rx_shift[FRAME_BITS-1:DATA_W];
        r_recv_data   <= r_rx_shift[DATA_W-1:0];
      end else if (r_recv_valid && bus.recv_ready) begin
        r_recv_valid <= 1'b0;
      end

      if (w_overrun || w_rx_timeout) r_rx_error <= 1'b1;
      else if (bus.err_clear)        r_rx_error <= 1'b0;
    end
  end

  assign bus.recv_valid  = r_recv_valid;
  assign bus.recv_opcode = r_recv_opcode;
  assign bus.recv_data   = r_recv_data;
  assign bus.rx_error    = r_rx_error;

endmodule
`default_nettype wire

// File: doc/serial_link_host.md
Name: serial_link_host

Overview:
Far-end endpoint of the two-wire clocked serial link between the robot controller and the processor's serial register bridge.
- TX side: serializes one opcode+data frame, drives data and a generated serial clock into the processor side.
- RX side: deserializes reply frames clocked by the processor side and hands them to host logic over a valid/ready interface.
- Runs in the host clock domain; the RX wires are asynchronous to it.

Parameters:
OPC_W, 5, opcode field width (frame MSBs)
DATA_W, 32, data field width (frame LSBs)
CLK_DIV, 4, system cycles per serial-clock half-period (>=2)
RX_TIMEOUT, 256, idle cycles that abort a partial RX frame

Ports:
clock  in  1  system clock; all state on rising edge
reset  in  1  asynchronous, active-high
send_valid  in  1  frame offered for transmit
send_ready  out  1  TX idle, can accept
send_opcode  in  OPC_W  TX opcode
send_data  in  DATA_W  TX data
serial_data_out  out  1  TX serial data, MSB first
serial_clock_out  out  1  TX serial clock, idle low
serial_data_in  in  1  RX serial data (async)
serial_clock_in  in  1  RX serial clock (async)
recv_valid  out  1  received frame held
recv_ready  in  1  host consumes frame
recv_opcode  out  OPC_W  received opcode
recv_data  out  DATA_W  received data
rx_error  out  1  sticky: overrun or timeout abort
err_clear  in  1  clears rx_error

Behaviour:
- Frame: FRAME_BITS = OPC_W+DATA_W, ordered {opcode, data}, MSB first.
- Data changes only while the serial clock is low; it is sampled on the serial clock rising edge.
- Reset values: send_ready=1, serial_clock_out=0, serial_data_out=0, recv_valid=0, recv_opcode=0, recv_data=0, rx_error=0. Internal counters and shift registers are also zero.
- TX FSM states: IDLE, LOW, HIGH, GAP.
  - IDLE: send_ready=1. A cycle with send_valid&send_ready is the accept cycle. The frame is captured, and in the next cycle send_ready=0 and serial_data_out=frame MSB; enter LOW.
  - LOW: lasts CLK_DIV cycles with clock 0, then goes to HIGH.
  - HIGH: lasts CLK_DIV cycles with clock 1. At its end:
    - if bits remain: shift, present the next bit, go to LOW;
    - after the last bit: go to GAP.
  - GAP: lasts CLK_DIV cycles with clock 0 and data 0, then returns to IDLE.
- send_ready returns to 1 exactly (2*FRAME_BITS+1)*CLK_DIV cycles after the accept cycle.
- send_* inputs are ignored while busy; no mid-frame abort.
- RX path:
  - serial_clock_in and serial_data_in each pass through a 2-flop synchronizer.
  - A rising edge of the synchronized clock shifts the synchronized data into the RX shift register and increments the bit counter.
  - When the counter reaches FRAME_BITS, the next cycle loads recv_opcode/recv_data, sets recv_valid=1, and clears the counter.
- recv_valid stays high until a cycle with recv_valid&recv_ready; it drops the next cycle. recv_* outputs stay stable while valid.
- Overrun: a frame that completes while recv_valid=1 and recv_ready=0 is dropped, the held frame is kept, and rx_error is set.
  - If recv_ready=1 in that same cycle, the new frame replaces the old one with no error.
- Timeout: if the bit counter is nonzero and no rising edge occurs for RX_TIMEOUT consecutive cycles, the partial frame is discarded, the counter is cleared, and rx_error is set.
- err_clear clears rx_error. If a set event occurs in the same cycle, set wins.
- Reset asserted mid-operation: every output returns to its reset value immediately (asynchronously), and any in-flight TX or RX frame is lost.
- TX and RX are fully independent; they may run simultaneously.

Decomposition:
- Package serial_link_pkg holds:
  - OPC_W, DATA_W and FRAME_BITS;
  - the TX state encoding (IDLE/LOW/HIGH/GAP);
  - the frame bit-counter width, $clog2(FRAME_BITS+1).
- Sub-module serial_sync_edge: 2-flop synchronizer plus rising-edge pulse, instantiated for the RX clock. The RX data uses its synchronized output only.

Test Plan:
- Reset mid-TX: assert reset mid-frame -> serial_clock_out=0, serial_data_out=0 and send_ready=1 asynchronously. After deassert, a new frame transmits cleanly.
- TX frame, CLK_DIV=2: send opcode=5'h15, data=32'hDEADBEEF.
  - 37 rising edges on serial_clock_out; bits sampled on rising edges equal 37'h15_DEADBEEF, MSB first.
  - send_ready is 0 for exactly 150 cycles after acceptance.
- RX loopback: drive 37 bits {5'h03, 32'h0000_0A5C} on the serial inputs with half-period 5 cycles.
  - recv_valid=1 with recv_opcode=3, recv_data=32'h0A5C.
  - Held for 10 cycles while recv_ready=0; drops 1 cycle after the handshake.
- Overrun: hold recv_ready=0 and send two frames -> the first frame is retained and rx_error=1. err_clear -> rx_error=0.
- Timeout: send 10 bits, then idle for 256 cycles -> rx_error=1. Then send a full frame -> received correctly with no bit misalignment.
- Concurrency: a TX frame and an RX frame overlapping in time -> both complete with correct values.
